// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
//   Shares one synchronous sprite ROM port between NUM_REQ sprite drawers.
//   Each cycle one pending request is granted, its address/bank is registered
//   onto the ROM port, and a {valid,id} tag travels down a 1+RD_LAT deep
//   pipeline so the ROM data can be steered back to the requester that
//   issued it.
//
//   Build option: define SPRITE_ARB_FIXED_PRIO_EN for fixed priority
//   (lowest index wins, no rotation pointer, i_frame_start ignored).
//   Default is round-robin, restarted at index 0 by i_frame_start.
//
// Ports
//   i_clk, i_rst_n  clock, async active-low reset
//   i_frame_start   one-cycle pulse at frame start (resets rotation pointer)
//   i_req           per-requester read request
//   i_req_addr      packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   i_req_bank      packed bank selects, same packing
//   o_gnt           one-hot grant, combinational from i_req
//   o_rom_addr      registered ROM address
//   o_rom_bank      registered ROM bank select
//   i_rom_data      ROM read data
//   o_rsp_valid     one-hot response strobe
//   o_rsp_data      response palette index (i_rom_data passed through)
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 14,
  parameter int BANK_W  = 2,
  parameter int DATA_W  = 3,
  parameter int RD_LAT  = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_frame_start,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*BANK_W-1:0] i_req_bank,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic [ADDR_W-1:0]         o_rom_addr,
  output logic [BANK_W-1:0]         o_rom_bank,
  input  logic [DATA_W-1:0]         i_rom_data,
  output logic [NUM_REQ-1:0]        o_rsp_valid,
  output logic [DATA_W-1:0]         o_rsp_data
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic            w_gnt_any;
  logic [ID_W-1:0] w_gnt_id;

`ifdef SPRITE_ARB_FIXED_PRIO_EN
  // Frame boundaries have no meaning without a rotation pointer.
  logic w_unused_fs;
  assign w_unused_fs = i_frame_start;

  // Descending scan: the last hit written is the lowest index.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0] r_ptr;

  // Scan offsets from far to near so the nearest set bit after r_ptr
  // is the last one written and therefore wins.
  always_comb begin
    int idx;
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    idx       = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = (int'(r_ptr) + off) % NUM_REQ;
      if (i_req[idx]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = ID_W'(idx);
      end
    end
  end

  // frame_start overrides the post-grant rotation; the grant itself still issues.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                     r_ptr <= '0;
    else if (i_frame_start)           r_ptr <= '0;
    else if (w_gnt_any) begin
      if (w_gnt_id == ID_W'(NUM_REQ - 1)) r_ptr <= '0;
      else                                r_ptr <= w_gnt_id + 1'b1;
    end
  end
`endif

  always_comb begin
    o_gnt = '0;
    if (w_gnt_any) o_gnt[w_gnt_id] = 1'b1;
  end

  // ROM issue register: holds its last value when nothing is granted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rom_addr <= '0;
      o_rom_bank <= '0;
    end else if (w_gnt_any) begin
      o_rom_addr <= i_req_addr[w_gnt_id*ADDR_W +: ADDR_W];
      o_rom_bank <= i_req_bank[w_gnt_id*BANK_W +: BANK_W];
    end
  end

  // Tag pipeline: stage 0 lines up with the issue register, stage RD_LAT
  // lines up with the cycle the ROM data is valid.
  logic [RD_LAT:0]           r_vld_pipe;
  logic [RD_LAT:0][ID_W-1:0] r_id_pipe;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld_pipe <= '0;
      r_id_pipe  <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[RD_LAT-1:0], w_gnt_any};
      r_id_pipe  <= {r_id_pipe[RD_LAT-1:0], w_gnt_id};
    end
  end

  always_comb begin
    o_rsp_valid = '0;
    if (r_vld_pipe[RD_LAT]) o_rsp_valid[r_id_pipe[RD_LAT]] = 1'b1;
  end

  assign o_rsp_data = i_rom_data;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter (NUM_REQ=4, RD_LAT=1).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// A behavioural 1-cycle ROM returns romf(addr, bank).
module tb_sprite_rom_arbiter;
  localparam int NR = 4, AW = 14, BW = 2, DW = 3, RL = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              frame_start;
  logic [NR-1:0]     req;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*BW-1:0]  req_bank;
  logic [NR-1:0]     gnt;
  logic [AW-1:0]     rom_addr;
  logic [BW-1:0]     rom_bank;
  logic [DW-1:0]     rom_data;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_data;

  int n_vec  = 0;
  int n_fail = 0;

  logic [AW-1:0] addr_t [NR];
  logic [BW-1:0] bank_t [NR];

  sprite_rom_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .BANK_W(BW), .DATA_W(DW), .RD_LAT(RL)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(frame_start),
    .i_req(req), .i_req_addr(req_addr), .i_req_bank(req_bank),
    .o_gnt(gnt), .o_rom_addr(rom_addr), .o_rom_bank(rom_bank),
    .i_rom_data(rom_data), .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] romf(input logic [AW-1:0] a, input logic [BW-1:0] b);
    return a[2:0] ^ a[5:3] ^ {1'b0, b};
  endfunction

  // Synchronous ROM, one cycle of read latency.
  always @(posedge clk) rom_data <= romf(rom_addr, rom_bank);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive on the falling edge, then check grant and response.
  task automatic cyc(input string tag, input logic [NR-1:0] r, input logic fs,
                     input logic [NR-1:0] eg, input logic [NR-1:0] er, input int rid);
    @(negedge clk);
    req = r;
    frame_start = fs;
    #1;
    chk({tag, ".gnt"}, gnt, eg);
    chk({tag, ".rsp_valid"}, rsp_valid, er);
    if (er != '0) chk({tag, ".rsp_data"}, rsp_data, romf(addr_t[rid], bank_t[rid]));
  endtask

  initial begin
    // 11663 is the last in-range word of a 108x108 frame.
    addr_t[0] = 14'd5;    bank_t[0] = 2'd0;
    addr_t[1] = 14'd1234; bank_t[1] = 2'd1;
    addr_t[2] = 14'd11663; bank_t[2] = 2'd2;
    addr_t[3] = 14'd777;  bank_t[3] = 2'd3;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW] = addr_t[i];
      req_bank[i*BW +: BW] = bank_t[i];
    end
    rst_n = 1'b0;
    frame_start = 1'b0;
    req = 4'b1111;

    // Held in reset: grant is still combinational from req.
    repeat (2) @(negedge clk);
    #1;
    chk("rst.gnt", gnt, 4'b0001);
    chk("rst.rom_addr", rom_addr, 0);
    chk("rst.rom_bank", rom_bank, 0);
    chk("rst.rsp_valid", rsp_valid, 0);

`ifdef SPRITE_ARB_FIXED_PRIO_EN
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("fp0.gnt", gnt, 4'b0001);
    cyc("fp1", 4'b1111, 1'b0, 4'b0001, 4'b0000, 0);
    cyc("fp2", 4'b1111, 1'b0, 4'b0001, 4'b0001, 0);
    cyc("fp3", 4'b1111, 1'b0, 4'b0001, 4'b0001, 0);
    cyc("fp4", 4'b0110, 1'b1, 4'b0010, 4'b0001, 0);
    cyc("fp5", 4'b0000, 1'b0, 4'b0000, 4'b0001, 0);
    cyc("fp6", 4'b0000, 1'b0, 4'b0000, 4'b0010, 1);
`else
    // Release reset with all four requesting: round-robin, responses 2 cycles later.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rr0.gnt", gnt, 4'b0001);
    chk("rr0.rsp_valid", rsp_valid, 0);
    for (int n = 1; n < 8; n++) begin
      cyc($sformatf("rr%0d", n), 4'b1111, 1'b0, 4'(1 << (n % 4)),
          (n >= 2) ? 4'(1 << ((n - 2) % 4)) : 4'b0000, (n - 2) % 4);
      if (n == 1) begin
        chk("rr1.rom_addr", rom_addr, addr_t[0]);
        chk("rr1.rom_bank", rom_bank, bank_t[0]);
      end
    end
    cyc("rr8", 4'b0000, 1'b0, 4'b0000, 4'b0100, 2);
    chk("rr8.rom_addr_hold", rom_addr, addr_t[3]);
    cyc("rr9", 4'b0000, 1'b0, 4'b0000, 4'b1000, 3);
    cyc("rr10", 4'b0000, 1'b0, 4'b0000, 4'b0000, 0);

    // Sparse: pointer at 0, requesters 1 and 3 only.
    cyc("sp0", 4'b1010, 1'b0, 4'b0010, 4'b0000, 0);
    cyc("sp1", 4'b1010, 1'b0, 4'b1000, 4'b0000, 0);
    cyc("sp2", 4'b0000, 1'b0, 4'b0000, 4'b0010, 1);
    cyc("sp3", 4'b0000, 1'b0, 4'b0000, 4'b1000, 3);

    // frame_start: grant 1 (ptr->2), then pulse with 0101 -> 2 wins, ptr forced to 0.
    // Without the force ptr would be 3 and 1101 would grant requester 3.
    cyc("fs0", 4'b0010, 1'b0, 4'b0010, 4'b0000, 0);
    cyc("fs1", 4'b0101, 1'b1, 4'b0100, 4'b0000, 0);
    cyc("fs2", 4'b1101, 1'b0, 4'b0001, 4'b0010, 1);
    cyc("fs3", 4'b0000, 1'b0, 4'b0000, 4'b0100, 2);
    cyc("fs4", 4'b0000, 1'b0, 4'b0000, 4'b0001, 0);

    // Reset mid-flight: grant 3 (ptr=1), reset next cycle, response must vanish.
    cyc("mf0", 4'b1000, 1'b0, 4'b1000, 4'b0000, 0);
    @(negedge clk);
    rst_n = 1'b0;
    req = 4'b0000;
    #1;
    chk("mf1.rsp_valid", rsp_valid, 0);
    chk("mf1.rom_addr", rom_addr, 0);
    chk("mf1.rom_bank", rom_bank, 0);
    chk("mf1.gnt", gnt, 0);
    @(negedge clk);
    #1;
    chk("mf2.rsp_valid", rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b0110;
    #1;
    // ptr back to 0 after reset, so 1 wins over 2.
    chk("mf3.gnt", gnt, 4'b0010);
    cyc("mf4", 4'b0000, 1'b0, 4'b0000, 4'b0000, 0);
    cyc("mf5", 4'b0000, 1'b0, 4'b0000, 4'b0010, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Round-robin arbiter and read sequencer that shares one synchronous sprite ROM port between up to NUM_REQ sprite drawers. The ROM holds 108x108 sprite frames selected by a bank index. Each drawer presents an address and a bank; the arbiter grants one request per cycle, drives the ROM, and routes the returned palette index back to the granted drawer through a tagged read pipeline. It sits between the per-sprite draw units and the single shared sprite ROM, in the pixel clock domain.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 14, ROM word address width (108*108 = 11664 words)
- BANK_W, 2, frame bank select width
- DATA_W, 3, palette index width
- RD_LAT, 1, ROM read latency in cycles from rom_addr change to rom_data valid (1..3)

- Clk  in  1  clock, all logic on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at start of each video frame
- req  in  NUM_REQ  per-requester read request
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_bank  in  NUM_REQ*BANK_W  packed bank selects, same packing
- gnt  out  NUM_REQ  one-hot grant, combinational in the request cycle
- rom_addr  out  ADDR_W  registered ROM address
- rom_bank  out  BANK_W  registered ROM bank (ROM cs)
- rom_data  in  DATA_W  ROM read data
- rsp_valid  out  NUM_REQ  one-hot response strobe
- rsp_data  out  DATA_W  response palette index, valid when any rsp_valid bit is set

## Operation
- State: round-robin pointer ptr (0..NUM_REQ-1), issue register (rom_addr, rom_bank), tag pipeline of depth 1+RD_LAT, each stage {valid, id}.
- Arbitration: scan req starting at index ptr, wrapping modulo NUM_REQ; the first set bit wins. gnt has at most one bit set. gnt is 0 when req is 0.
- A request is consumed only in a cycle where its gnt bit is 1. A requester holds req, req_addr and req_bank stable until granted. Dropping req before grant is legal and loses nothing.
- On grant to i: rom_addr/rom_bank load requester i's fields at the clock edge, tag stage 0 loads {1, i}, and ptr becomes (i+1) mod NUM_REQ.
- No grant: rom_addr/rom_bank hold, tag stage 0 loads valid=0, ptr holds.
- frame_start: ptr forced to 0 at the edge, overriding the grant update. The grant in that same cycle is still issued normally. In-flight responses complete unaffected.
- Response: rsp_valid[id] = last tag stage valid. rsp_data = rom_data passed through combinationally. rsp_data is don't-care when no rsp_valid bit is set.
- Reset values: ptr=0, rom_addr=0, rom_bank=0, all tag valid=0, rsp_valid=0, gnt=0 (no req). Reset mid-operation discards all in-flight reads; no response is produced for them.
- Bank and address are passed through unchecked. Out-of-range addresses (>=11664) return whatever the ROM returns.

## Timing
- Request cycle T: gnt valid in T.
- rom_addr/rom_bank valid from T+1.
- rom_data valid at T+1+RD_LAT.
- rsp_valid pulses for exactly one cycle at T+1+RD_LAT.
- Throughput: one grant per cycle. Back-to-back grants produce back-to-back responses in grant order.
- Fairness: with all NUM_REQ requesting continuously, each is granted exactly once per NUM_REQ cycles.
- No combinational path from rom_data to gnt. The req to gnt path is the only combinational input-to-output path besides rom_data to rsp_data.

## Configuration
- SPRITE_ARB_FIXED_PRIO_EN defined: fixed priority arbitration, lowest index wins. ptr is removed and frame_start is ignored. All other behaviour is identical.
- Not defined: round-robin as described above.

## Test plan
- Reset: hold Reset_n=0 with req=4'b1111. Expect gnt=4'b0001 combinationally, rom_addr=0, rsp_valid=0. Release reset; expect the first rsp_valid=4'b0001 at cycle 1+RD_LAT after release.
- Round-robin: req=4'b1111 held for 8 cycles with RD_LAT=1. Expect gnt sequence 0001,0010,0100,1000,0001,... and rsp_valid with the same sequence delayed 2 cycles. rsp_data matches the ROM model at each requester's address.
- Sparse/skip: ptr=0, req=4'b1010. Expect gnt=0010, then 1000 the next cycle; requesters 0 and 2 are never granted.
- frame_start: after a grant to requester 1 (ptr=2), pulse frame_start with req=4'b0101. Expect gnt=0100 in that cycle and gnt=0001 the next cycle (ptr was forced to 0).
- Reset mid-flight: grant requester 3 at T, assert Reset_n=0 at T+1. Expect no rsp_valid at T+2 and all outputs at reset values.
- With SPRITE_ARB_FIXED_PRIO_EN: req=4'b1111 for 4 cycles. Expect gnt=0001 every cycle.
